r5p_issue_ctl: RTL

R5P_ISSUE_CTL -- requirements
Module: r5p_issue_ctl

---
 rtl/r5p_issue_ctl_pkg.sv | 10 +
 rtl/riscv_isa_pkg.sv | 43 ++++
 rtl/r5p_scoreboard.sv | 52 +++++
 rtl/r5p_issue_ctl.sv | 117 +++++++++++
 4 files changed

// File: rtl/r5p_issue_ctl_pkg.sv
// Issue-controller local types: buffer state encoding, visible on the debug port.
package r5p_issue_ctl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HAZARD = 2'd1,
        ST_ISSUE  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/riscv_isa_pkg.sv
// Shared RV32I definitions: base opcodes, instruction field views and the canonical NOP.
package riscv_isa_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } op32_r_t;

    typedef struct packed {
        logic [11:0] imm_11_0;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } op32_i_t;

    typedef union packed {
        op32_r_t r;
        op32_i_t i;
    } op32_t;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/r5p_scoreboard.sv
// Register busy scoreboard with outstanding-writer counter; issue-set wins over writeback-clear.
module r5p_scoreboard #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_vld,
    input  logic [4:0]  set_rd,
    input  logic        clr_vld,
    input  logic [4:0]  clr_rd,
    output logic [31:0] busy,
    output logic [3:0]  cnt
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        set_en, clr_en;

    always_comb begin
        set_en = set_vld && (set_rd != 5'd0);
        // A writeback with nothing outstanding is dropped entirely.
        clr_en = clr_vld && (clr_rd != 5'd0) && (cnt_q != 4'd0);

        busy_d = busy_q;
        if (clr_en) busy_d[clr_rd] = 1'b0;
        if (set_en) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (set_en && !clr_en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
        end else if (clr_en && !set_en) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/r5p_issue_ctl.sv
// One-entry issue buffer: holds a fetched instruction until its operands and destination are free.
// Handshakes: a beat moves on a rising edge where valid and ready are both high; ready may depend on the same-cycle out transfer.
module r5p_issue_ctl
    import riscv_isa_pkg::*;
    import r5p_issue_ctl_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ifu_vld,
    input  logic [31:0]  ifu_ins,
    output logic         ifu_rdy,
    output logic         idu_vld,
    output logic [31:0]  idu_ins,
    output logic [4:0]   idu_rd,
    output logic [4:0]   idu_rs1,
    output logic [4:0]   idu_rs2,
    output logic [11:0]  idu_imm,
    input  logic         idu_rdy,
    input  logic         wbu_vld,
    input  logic [4:0]   wbu_rd,
    input  logic         flush,
    output logic [31:0]  busy,
    output logic [3:0]   cnt,
    output issue_state_e dbg_state
);

    localparam logic [3:0] CNT_MAX = 4'(MAX_OUT);

    issue_state_e state_q, state_d;
    op32_t        ins_q, ins_d;
    logic         writer, chk_rs1, chk_rs2, hazard;
    logic         in_xfer, out_xfer;

    always_comb begin
        writer  = 1'b0;
        chk_rs1 = 1'b1;
        chk_rs2 = 1'b0;
        case (ins_q.r.opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writer  = 1'b1;
                chk_rs1 = 1'b0;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: writer = 1'b1;
            OPC_OP: begin
                writer  = 1'b1;
                chk_rs2 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: chk_rs2 = 1'b1;
            default: ;
        endcase
        if (ins_q.r.rd == 5'd0) writer = 1'b0;

        // Registered scoreboard only: a writeback releases the stall one cycle later.
        hazard = (chk_rs1 && busy[ins_q.r.rs1])
              || (chk_rs2 && busy[ins_q.r.rs2])
              || (writer && busy[ins_q.r.rd])
              || (writer && (cnt == CNT_MAX));
    end

    always_comb begin
        idu_vld  = !rst && !flush && (state_q == ST_ISSUE) && !hazard;
        out_xfer = idu_vld && idu_rdy;
        ifu_rdy  = !rst && !flush && ((state_q == ST_EMPTY) || out_xfer);
        in_xfer  = ifu_vld && ifu_rdy;

        ins_d = ins_q;
        if (in_xfer) ins_d = ifu_ins;

        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  if (in_xfer) state_d = ST_ISSUE;
                ST_ISSUE: begin
                    if (hazard)        state_d = ST_HAZARD;
                    else if (out_xfer) state_d = in_xfer ? ST_ISSUE : ST_EMPTY;
                end
                ST_HAZARD: if (!hazard) state_d = ST_ISSUE;
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ins_q   <= NOP;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
        end
    end

    r5p_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_vld (out_xfer && writer),
        .set_rd  (ins_q.r.rd),
        .clr_vld (wbu_vld),
        .clr_rd  (wbu_rd),
        .busy    (busy),
        .cnt     (cnt)
    );

    assign idu_ins   = ins_q;
    assign idu_rd    = ins_q.r.rd;
    assign idu_rs1   = ins_q.r.rs1;
    assign idu_rs2   = ins_q.r.rs2;
    assign idu_imm   = ins_q.i.imm_11_0;
    assign dbg_state = state_q;

endmodule
